// File: rtl/doodle_pkg.sv
// Shared constants for the doodle_y platform pipeline: screen geometry,
// platform layout and the reset placement table.
package doodle_pkg;

  typedef logic [9:0] pos_t;

  localparam int unsigned NUM_PLAT    = 7;
  localparam int unsigned PLAT_WIDTH  = 75;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SPACING     = 70;
  localparam int unsigned RESPAWN_V   = 490;
  localparam int unsigned DOODLE_SIZE = 20;
  localparam pos_t        LFSR_SEED   = 10'h2A5;

  // p4 sits mid-screen so the doodle starts centred on it.
  localparam pos_t RESET_HPOS [NUM_PLAT] = '{
    10'd40, 10'd480, 10'd150, 10'd280, 10'd60, 10'd400, 10'd220
  };

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) with zero-lockout recovery.
module lfsr10
  import doodle_pkg::*;
#(
  parameter pos_t SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] q
);

  pos_t lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    // All-zero is a dead state for an XOR LFSR; reseed out of it.
    if (lfsr_q == '0) lfsr_d = SEED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/platform_gen.sv
// Owns the seven platform positions: scrolls them up on each tick, respawns
// wrapped platforms at the bottom with an LFSR-derived x, and counts respawns.
module platform_gen #(
  parameter int unsigned SPACING    = doodle_pkg::SPACING,
  parameter int unsigned RESPAWN_V  = doodle_pkg::RESPAWN_V,
  parameter int unsigned SCREEN_W   = doodle_pkg::SCREEN_W,
  parameter int unsigned PLAT_WIDTH = doodle_pkg::PLAT_WIDTH,
  parameter logic [9:0]  LFSR_SEED  = doodle_pkg::LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        platform_tick,
  input  logic        terminated,
  output logic [9:0]  p1_vpos,
  output logic [9:0]  p2_vpos,
  output logic [9:0]  p3_vpos,
  output logic [9:0]  p4_vpos,
  output logic [9:0]  p5_vpos,
  output logic [9:0]  p6_vpos,
  output logic [9:0]  p7_vpos,
  output logic [9:0]  p1_hpos,
  output logic [9:0]  p2_hpos,
  output logic [9:0]  p3_hpos,
  output logic [9:0]  p4_hpos,
  output logic [9:0]  p5_hpos,
  output logic [9:0]  p6_hpos,
  output logic [9:0]  p7_hpos,
  output logic [15:0] score
);

  import doodle_pkg::pos_t;
  import doodle_pkg::NUM_PLAT;
  import doodle_pkg::RESET_HPOS;

  localparam pos_t SPAWN_RANGE = pos_t'(SCREEN_W - PLAT_WIDTH);
  localparam pos_t RELOAD_V    = pos_t'(RESPAWN_V);

  pos_t        vpos_q [NUM_PLAT];
  pos_t        vpos_d [NUM_PLAT];
  pos_t        hpos_q [NUM_PLAT];
  pos_t        hpos_d [NUM_PLAT];
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;
  logic [2:0]  wrap_cnt;
  logic        step_en;
  pos_t        lfsr;
  pos_t        spawn_x;

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // A single subtract folds 565..1023 into range since 1023 - 565 < 565.
  always_comb spawn_x = (lfsr < SPAWN_RANGE) ? lfsr : lfsr - SPAWN_RANGE;

  assign step_en = platform_tick && !terminated;

  always_comb begin
    wrap_cnt = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      vpos_d[i] = vpos_q[i];
      hpos_d[i] = hpos_q[i];
      if (step_en) begin
        if (vpos_q[i] == '0) begin
          vpos_d[i] = RELOAD_V;
          hpos_d[i] = spawn_x;
          wrap_cnt  = wrap_cnt + 3'd1;
        end else begin
          vpos_d[i] = vpos_q[i] - 10'd1;
        end
      end
    end
    score_sum = {1'b0, score_q} + 17'(wrap_cnt);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        vpos_q[i] <= pos_t'((i + 1) * SPACING);
        hpos_q[i] <= RESET_HPOS[i];
      end
      score_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        vpos_q[i] <= vpos_d[i];
        hpos_q[i] <= hpos_d[i];
      end
      score_q <= score_d;
    end
  end

  assign p1_vpos = vpos_q[0];
  assign p2_vpos = vpos_q[1];
  assign p3_vpos = vpos_q[2];
  assign p4_vpos = vpos_q[3];
  assign p5_vpos = vpos_q[4];
  assign p6_vpos = vpos_q[5];
  assign p7_vpos = vpos_q[6];
  assign p1_hpos = hpos_q[0];
  assign p2_hpos = hpos_q[1];
  assign p3_hpos = hpos_q[2];
  assign p4_hpos = hpos_q[3];
  assign p5_hpos = hpos_q[4];
  assign p6_hpos = hpos_q[5];
  assign p7_hpos = hpos_q[6];
  assign score   = score_q;

endmodule

// File: tb/tb_platform_gen.sv
// Directed bench for platform_gen: reset layout, scrolling, wrap/respawn,
// tick gating, freeze, score saturation, spawn mapping and async reset.
module tb_platform_gen;

  localparam logic [9:0] SEED = 10'h2A5;

  logic        clk;
  logic        rst;
  logic        platform_tick;
  logic        terminated;
  logic [9:0]  p1_vpos, p2_vpos, p3_vpos, p4_vpos, p5_vpos, p6_vpos, p7_vpos;
  logic [9:0]  p1_hpos, p2_hpos, p3_hpos, p4_hpos, p5_hpos, p6_hpos, p7_hpos;
  logic [15:0] score;

  logic [9:0]  v [7];
  logic [9:0]  h [7];

  // reference state, advanced once per clock edge by cycle()
  logic [9:0]  mv [7];
  logic [9:0]  mh [7];
  logic [15:0] m_score;
  logic [9:0]  m_lfsr;

  int n_cmp = 0;
  int n_bad = 0;

  platform_gen dut (
    .clk           (clk),
    .rst           (rst),
    .platform_tick (platform_tick),
    .terminated    (terminated),
    .p1_vpos (p1_vpos), .p2_vpos (p2_vpos), .p3_vpos (p3_vpos), .p4_vpos (p4_vpos),
    .p5_vpos (p5_vpos), .p6_vpos (p6_vpos), .p7_vpos (p7_vpos),
    .p1_hpos (p1_hpos), .p2_hpos (p2_hpos), .p3_hpos (p3_hpos), .p4_hpos (p4_hpos),
    .p5_hpos (p5_hpos), .p6_hpos (p6_hpos), .p7_hpos (p7_hpos),
    .score   (score)
  );

  assign v[0] = p1_vpos; assign v[1] = p2_vpos; assign v[2] = p3_vpos; assign v[3] = p4_vpos;
  assign v[4] = p5_vpos; assign v[5] = p6_vpos; assign v[6] = p7_vpos;
  assign h[0] = p1_hpos; assign h[1] = p2_hpos; assign h[2] = p3_hpos; assign h[3] = p4_hpos;
  assign h[4] = p5_hpos; assign h[5] = p6_hpos; assign h[6] = p7_hpos;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] lfsr_step(input logic [9:0] x);
    if (x == 10'd0) return SEED;
    return {x[8:0], x[9] ^ x[6]};
  endfunction

  function automatic logic [9:0] spawn(input logic [9:0] x);
    return (x < 10'd565) ? x : x - 10'd565;
  endfunction

  // Drive one clock edge; the reference model uses the pre-edge LFSR value.
  task automatic cycle(input bit tick);
    logic [16:0] sum;
    int nw;
    @(negedge clk);
    platform_tick = tick;
    nw = 0;
    if (tick && !terminated) begin
      for (int i = 0; i < 7; i++) begin
        if (mv[i] == 10'd0) begin
          mv[i] = 10'd490;
          mh[i] = spawn(m_lfsr);
          nw++;
        end else begin
          mv[i] = mv[i] - 10'd1;
        end
      end
    end
    sum = {1'b0, m_score} + 17'(nw);
    m_score = (sum > 17'h0FFFF) ? 16'hFFFF : sum[15:0];
    m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to_wrap(output int idx);
    idx = -1;
    for (int k = 0; k < 600 && idx < 0; k++) begin
      for (int i = 0; i < 7; i++) if (mv[i] == 10'd0 && idx < 0) idx = i;
      if (idx < 0) cycle(1'b1);
    end
    if (idx < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_timeout: no platform reached vpos 0 within 600 ticks");
      idx = 0;
    end
  endtask

  task automatic test_reset(input string name);
    int exp_v [7] = '{70, 140, 210, 280, 350, 420, 490};
    int exp_h [7] = '{40, 480, 150, 280, 60, 400, 220};
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (v[i] !== 10'(exp_v[i])) begin
        n_bad++;
        $display("FAIL %s_vpos[%0d]: got %0d want %0d", name, i + 1, v[i], exp_v[i]);
      end
      n_cmp++;
      if (h[i] !== 10'(exp_h[i])) begin
        n_bad++;
        $display("FAIL %s_hpos[%0d]: got %0d want %0d", name, i + 1, h[i], exp_h[i]);
      end
      mv[i] = 10'(exp_v[i]);
      mh[i] = 10'(exp_h[i]);
    end
    n_cmp++;
    if (score !== 16'd0) begin
      n_bad++;
      $display("FAIL %s_score: got %0d want 0", name, score);
    end
    n_cmp++;
    if (dut.lfsr !== SEED) begin
      n_bad++;
      $display("FAIL %s_lfsr: got %h want %h", name, dut.lfsr, SEED);
    end
    m_score = 16'd0;
    m_lfsr  = SEED;
    platform_tick = 1'b0;
    terminated = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_scroll_wrap();
    logic [9:0] exp_h1;
    repeat (70) cycle(1'b1);
    n_cmp++;
    if (p1_vpos !== 10'd0) begin n_bad++; $display("FAIL scroll70_p1_vpos: got %0d want 0", p1_vpos); end
    n_cmp++;
    if (p2_vpos !== 10'd70) begin n_bad++; $display("FAIL scroll70_p2_vpos: got %0d want 70", p2_vpos); end
    n_cmp++;
    if (score !== 16'd0) begin n_bad++; $display("FAIL scroll70_score: got %0d want 0", score); end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (v[i] !== mv[i] || h[i] !== mh[i]) begin
        n_bad++;
        $display("FAIL scroll70_plat[%0d]: got %0d/%0d want %0d/%0d", i + 1, v[i], h[i], mv[i], mh[i]);
      end
    end
    exp_h1 = spawn(m_lfsr);
    cycle(1'b1);
    n_cmp++;
    if (p1_vpos !== 10'd490) begin n_bad++; $display("FAIL wrap_p1_vpos: got %0d want 490", p1_vpos); end
    n_cmp++;
    if (p1_hpos !== exp_h1 || p1_hpos >= 10'd565) begin
      n_bad++;
      $display("FAIL wrap_p1_hpos: got %0d want %0d", p1_hpos, exp_h1);
    end
    n_cmp++;
    if (p2_vpos !== 10'd69) begin n_bad++; $display("FAIL wrap_p2_vpos: got %0d want 69", p2_vpos); end
    n_cmp++;
    if (score !== 16'd1) begin n_bad++; $display("FAIL wrap_score: got %0d want 1", score); end
  endtask

  task automatic test_tick_gating();
    repeat (1000) cycle(1'b0);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (v[i] !== mv[i] || h[i] !== mh[i]) begin
        n_bad++;
        $display("FAIL gate_plat[%0d]: got %0d/%0d want %0d/%0d", i + 1, v[i], h[i], mv[i], mh[i]);
      end
    end
    n_cmp++;
    if (score !== m_score) begin n_bad++; $display("FAIL gate_score: got %0d want %0d", score, m_score); end
    n_cmp++;
    if (dut.lfsr !== m_lfsr || dut.lfsr === SEED) begin
      n_bad++;
      $display("FAIL gate_lfsr: got %h want %h (must differ from seed)", dut.lfsr, m_lfsr);
    end
  endtask

  task automatic test_freeze();
    logic [9:0] snap [7];
    terminated = 1'b1;
    repeat (50) cycle(1'b1);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (v[i] !== mv[i] || h[i] !== mh[i]) begin
        n_bad++;
        $display("FAIL freeze_plat[%0d]: got %0d/%0d want %0d/%0d", i + 1, v[i], h[i], mv[i], mh[i]);
      end
    end
    n_cmp++;
    if (score !== 16'd1) begin n_bad++; $display("FAIL freeze_score: got %0d want 1", score); end
    terminated = 1'b0;
    for (int i = 0; i < 7; i++) snap[i] = mv[i];
    cycle(1'b1);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (v[i] !== ((snap[i] == 10'd0) ? 10'd490 : snap[i] - 10'd1)) begin
        n_bad++;
        $display("FAIL resume_vpos[%0d]: got %0d want %0d", i + 1, v[i], snap[i] - 10'd1);
      end
    end
  endtask

  task automatic test_saturation();
    int idx;
    advance_to_wrap(idx);
    force dut.score_d = 16'hFFFE;
    cycle(1'b0);
    release dut.score_d;
    m_score = 16'hFFFE;
    n_cmp++;
    if (score !== 16'hFFFE) begin n_bad++; $display("FAIL sat_preload: got %h want FFFE", score); end
    cycle(1'b1);
    n_cmp++;
    if (score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_first: got %h want FFFF", score); end
    n_cmp++;
    if (v[idx] !== 10'd490) begin n_bad++; $display("FAIL sat_wrap_vpos: got %0d want 490", v[idx]); end
    advance_to_wrap(idx);
    cycle(1'b1);
    n_cmp++;
    if (score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_second: got %h want FFFF", score); end
  endtask

  task automatic test_spawn_map();
    int tgt   [4] = '{300, 565, 700, 1023};
    int exp_x [4] = '{300, 0, 135, 458};
    int idx;
    for (int t = 0; t < 4; t++) begin
      advance_to_wrap(idx);
      for (int k = 0; k < 1100 && m_lfsr != 10'(tgt[t]); k++) cycle(1'b0);
      n_cmp++;
      if (dut.lfsr !== 10'(tgt[t])) begin
        n_bad++;
        $display("FAIL spawn_lfsr_%0d: got %0d want %0d", tgt[t], dut.lfsr, tgt[t]);
      end
      cycle(1'b1);
      n_cmp++;
      if (h[idx] !== 10'(exp_x[t]) || v[idx] !== 10'd490) begin
        n_bad++;
        $display("FAIL spawn_map_%0d: got hpos %0d vpos %0d want %0d/490", tgt[t], h[idx], v[idx], exp_x[t]);
      end
    end
  endtask

  task automatic test_zero_lockout();
    force dut.u_lfsr.lfsr_q = 10'd0;
    #1;
    n_cmp++;
    if (dut.u_lfsr.lfsr_d !== SEED) begin
      n_bad++;
      $display("FAIL lfsr_zero_guard: got %h want %h", dut.u_lfsr.lfsr_d, SEED);
    end
    release dut.u_lfsr.lfsr_q;
  endtask

  initial begin
    rst = 1'b1;
    platform_tick = 1'b0;
    terminated = 1'b0;
    #12;
    rst = 1'b0;
    test_reset("reset");
    test_scroll_wrap();
    test_tick_gating();
    test_freeze();
    test_saturation();
    test_spawn_map();
    test_zero_lockout();
    repeat (5) cycle(1'b1);
    test_reset("async_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/platform_gen.md
Name: platform_gen

Overview:
- Upstream stage of doodle_y: owns the seven platforms' positions.
- Scrolls all platforms up one pixel per scroll tick.
- Respawns any platform leaving the top at the bottom, with a pseudo-random horizontal position.
- Counts respawns as the score.
- Outputs feed doodle_y (p*_vpos/p*_hpos) and the VGA renderer directly.

Parameters:
- SPACING, 70: vertical pitch between adjacent platforms, in pixels.
- RESPAWN_V, 490: vpos loaded on wrap; equals 7*SPACING.
- SCREEN_W, 640: visible width in pixels.
- PLAT_WIDTH, 75: platform width in pixels; must match doodle_y.
- LFSR_SEED, 10'h2A5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- platform_tick  in  1  one-clk-wide scroll enable from the scroll divider
- terminated  in  1  game over; freezes platforms and score
- p1_vpos..p7_vpos  out  10 each  platform top-edge y, registered
- p1_hpos..p7_hpos  out  10 each  platform left-edge x, registered
- score  out  16  respawn count, saturating

Behaviour:
- Single clock domain. rst is asynchronous, active-high; it takes effect immediately, independent of clk.
- Reset values:
  - pN_vpos = N*SPACING, giving 70, 140, 210, 280, 350, 420, 490.
  - hpos for p1..p7 = 40, 480, 150, 280, 60, 400, 220. p4 = 280 so the doodle starts centred on p4.
  - score = 0; lfsr = LFSR_SEED.
- LFSR:
  - 10-bit Fibonacci, taps x^10 + x^7 + 1, shift left, feedback = bit9 ^ bit6 into bit0.
  - Advances every clk edge, including while terminated, so respawn position depends on player timing.
  - If the state ever reads 0, load LFSR_SEED on the next edge.
- Spawn x mapping (combinational from lfsr), RANGE = SCREEN_W - PLAT_WIDTH = 565:
  - lfsr < 565 -> hpos = lfsr.
  - otherwise -> hpos = lfsr - 565.
  - Result is always 0..564; one subtract suffices because 1023 - 565 < 565.
- Scroll step, on a clk edge where platform_tick = 1 and terminated = 0, for each N independently:
  - pN_vpos != 0 -> pN_vpos <= pN_vpos - 1; hpos unchanged.
  - pN_vpos == 0 -> pN_vpos <= RESPAWN_V; pN_hpos <= spawn_x, using the pre-edge lfsr value.
- Score:
  - Increments by the number of platforms wrapping in that step.
  - Saturates at 16'hFFFF (no wrap-around).
  - With reset spacing at most one platform wraps per step. If several wrap anyway, all take the same spawn_x and score adds the count, saturating.
- Hold conditions:
  - platform_tick = 0: positions and score hold, regardless of how many clk cycles elapse.
  - terminated = 1: positions and score hold even when platform_tick = 1.
  - terminated deasserting: scrolling resumes on the next tick. There is no catch-up for ticks missed while frozen.
- Latency: outputs change on the same clk edge that samples platform_tick high, i.e. one registered stage.
- Width rules: all position arithmetic is 10-bit unsigned. The decrement never underflows because 0 triggers reload.
- Reset mid-operation: all state returns to reset values immediately. The first tick after release starts from the reset layout.

Decomposition:
- Shared package doodle_pkg holds:
  - PLAT_WIDTH, SCREEN_W, SCREEN_H, SPACING, RESPAWN_V, DOODLE_SIZE (20).
  - The reset hpos table.
  - The same constants are used by doodle_y and the renderer.
- One sub-module lfsr10:
  - Ports: clk, rst, 10-bit q.
  - Contains the seed and the zero-lockout guard.
- Per-platform update logic is replicated inline for all seven platforms; no further sub-modules.

Test Plan:
- Reset: pulse rst -> vpos 70/140/210/280/350/420/490; hpos 40/480/150/280/60/400/220; score = 0. All values appear without a clk edge.
- Scroll/wrap:
  - 70 ticks -> p1_vpos = 0, p2_vpos = 70, score = 0.
  - 71st tick -> p1_vpos = 490, p1_hpos = spawn_x(lfsr before that edge) and < 565, p2_vpos = 69, score = 1.
- Tick gating: 1000 clk cycles with platform_tick = 0 -> all outputs unchanged; LFSR state differs from seed.
- Freeze:
  - terminated = 1, then 50 ticks -> outputs unchanged.
  - Deassert, then 1 tick -> every vpos decrements by exactly 1.
- Spawn mapping (force lfsr via sub-module): lfsr 300 -> 300, 565 -> 0, 700 -> 135, 1023 -> 458. Also force lfsr = 0 -> next state = LFSR_SEED.
- Saturation and async reset:
  - Preload score = 16'hFFFE, then drive two wraps -> FFFF, then FFFF.
  - Assert rst between clk edges mid-run -> immediate return to reset values.
